mul_div_unit: RTL
=================

# mul_div_unit

Multi-cycle multiply/divide unit in the EX stage, directly upstream of the HI/LO register. Accepts MULT/MULTU/DIV/DIVU operations from the issuing stage and produces a 64-bit {HI, LO} result with a one-cycle write-enable pulse that drives the HI/LO register's `hilo_input`/`wen` pins. Multiplies complete in one cycle; divides use a 32-iteration radix-2 restoring divider and hold `busy` so the pipeline stalls.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs operand (multiplicand / dividend).
- `src_b`  in  32  rt operand (multiplier / divisor).
- `cancel`  in  1  flush from exception/redirect; aborts the in-flight operation.
- `busy`  out  1  registered; high while the state is not IDLE.
- `hilo_result`  out  64  {HI, LO}; to `hilo_input` of the HI/LO register.
- `hilo_wen`  out  1  registered one-cycle write pulse; to `wen` of the HI/LO register.

## Operation
- States: IDLE, FAST, DIV.
- IDLE: `start`=1 and `cancel`=0 at a rising edge latch `op`, `src_a`, `src_b`. MULT/MULTU → FAST. DIV/DIVU with `src_b`≠0 → DIV (iteration counter cleared). DIV/DIVU with `src_b`=0 → FAST.
- FAST: at the next edge, register the result, set `hilo_wen`=1, go to IDLE.
- MULT: signed 32×32→64 product; MULTU: unsigned. HI = product[63:32], LO = product[31:0].
- DIV: one quotient bit per cycle for 32 cycles on magnitudes (signed ops: absolute values of operands). On the 32nd iteration, apply sign fixup, register the result, set `hilo_wen`=1, go to IDLE.
- Sign rules (DIV): quotient negative iff the signs of `src_a` and `src_b` differ; remainder takes the sign of `src_a`. HI = remainder, LO = quotient.
- Divide by zero (both DIV and DIVU): HI = `src_a`, LO = 32'hFFFF_FFFF, via FAST.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- `start` is ignored in FAST/DIV. Upstream issues `start` as a one-cycle pulse and ORs it into its own stall for the launch cycle.
- `cancel`=1 at any edge forces IDLE and suppresses the `hilo_wen` that edge would have set. This includes the completing edge. A pulse already on `hilo_wen` is not revoked.
- `hilo_result` holds its last value between operations; it is updated only on completion.

## Timing
- Reset: state IDLE, `busy`=0, `hilo_wen`=0, `hilo_result`=0, counter=0, operand registers 0.
- Launch at edge k:
  - MULT/MULTU/divide-by-zero: `busy` high for cycle k→k+1. `hilo_wen` high for cycle k+1→k+2.
  - DIV/DIVU: `busy` high for cycles k→k+32. `hilo_wen` high for cycle k+32→k+33.
- `hilo_wen` and `hilo_result` change only on rising edges, so they are stable across the intervening falling edge where the HI/LO register captures.
- Back-to-back: a new `start` is accepted at the edge where `hilo_wen` rises (state already IDLE is not required). In practice the earliest accept is edge k+1 (FAST) or k+32 (DIV), when the state is IDLE again.
- `reset` mid-operation: immediate return to reset values; no write.

## Configuration
- `MDU_DIV_EN` defined:
  - Divider, DIV state and iteration counter are compiled in.
  - Behaviour is as specified above.
- `MDU_DIV_EN` undefined:
  - Divider, DIV state and counter are removed.
  - DIV/DIVU go through FAST with `busy` high for one cycle and `hilo_wen` held 0, so HI/LO are left unchanged.
  - Multiply behaviour is unchanged.

## Test plan
- Reset asserted mid-DIV (cycle 10) → `busy`=0, `hilo_wen`=0, `hilo_result`=0 immediately. No write follows.
- MULT, `src_a`=0xFFFF_FFFE (−2), `src_b`=3 → one cycle later `hilo_result`=0xFFFF_FFFF_FFFF_FFFA, `hilo_wen` high for exactly one cycle. MULTU with the same operands → 0x0000_0002_FFFF_FFFA.
- DIV, `src_a`=−7 (0xFFFF_FFF9), `src_b`=2 → `busy` high 32 cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100/7 → LO=14, HI=2.
- DIVU by zero, `src_a`=0x1234_5678 → after one cycle HI=0x1234_5678, LO=0xFFFF_FFFF. DIV 0x8000_0000/−1 → LO=0x8000_0000, HI=0.
- DIV launched, `cancel` at cycle 5, and separately `cancel` on the completing edge → no `hilo_wen`. A `start` pulse during `busy` is ignored, and the next `start` from IDLE runs normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: multiply/divide unit in EX feeding the HI/LO register.
// Multiplies finish in one cycle; divides use a 32-iteration radix-2
// restoring divider and hold busy so the pipeline stalls.
// Build option: define MDU_DIV_EN to compile in the divider. Without it,
// DIV/DIVU pass through FAST for one busy cycle and never write HI/LO.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [63:0] hilo_result,
  output logic        hilo_wen
);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAST = 2'd1,
    DIV  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAST = 2'd1
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] srcA_q, srcA_d;
  logic [31:0] srcB_q, srcB_d;
  logic [63:0] result_q, result_d;
  logic        wen_q, wen_d;
  logic        busy_q, busy_d;
  logic        canLaunch;

  // Multiplier operands are sign- or zero-extended to 64 bits so that a
  // single truncated 64-bit product serves both MULT and MULTU.
  logic        mulSigned;
  logic [63:0] mulA, mulB, product;

  assign mulSigned = ~op_q[0];
  assign mulA      = {{32{mulSigned & srcA_q[31]}}, srcA_q};
  assign mulB      = {{32{mulSigned & srcB_q[31]}}, srcB_q};
  assign product   = mulA * mulB;

`ifdef MDU_DIV_EN
  logic [4:0]  divCnt_q, divCnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        negQuo_q, negQuo_d;
  logic        negRem_q, negRem_d;
  logic [31:0] divisorMag;
  logic [31:0] launchDividendMag;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] subRes, remStep, quoStep, remFinal, quoFinal;

  // The divider works on magnitudes; signs are restored on the final step.
  // The quotient register starts out holding the dividend magnitude and its
  // top bit is shifted into the partial remainder every iteration.
  assign divisorMag        = (~op_q[0] & srcB_q[31]) ? (~srcB_q + 32'd1) : srcB_q;
  assign launchDividendMag = (~op[0] & src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign shifted           = {rem_q, quo_q[31]};
  assign fits              = (shifted >= {1'b0, divisorMag});
  assign subRes            = shifted[31:0] - divisorMag;
  assign remStep           = fits ? subRes : shifted[31:0];
  assign quoStep           = {quo_q[30:0], fits};
  assign remFinal          = negRem_q ? (~remStep + 32'd1) : remStep;
  assign quoFinal          = negQuo_q ? (~quoStep + 32'd1) : quoStep;
`endif

  // Next-state, datapath and write-pulse logic; completing edges may launch
  // the next operation, and cancel overrides everything else.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    srcA_d    = srcA_q;
    srcB_d    = srcB_q;
    result_d  = result_q;
    wen_d     = 1'b0;
    canLaunch = 1'b0;
`ifdef MDU_DIV_EN
    divCnt_d  = divCnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
`endif

    case (state_q)
      IDLE: begin
        canLaunch = 1'b1;
      end
      FAST: begin
        state_d   = IDLE;
        canLaunch = 1'b1;
        if (!op_q[1]) begin
          result_d = product;
          wen_d    = 1'b1;
        end
`ifdef MDU_DIV_EN
        else begin
          result_d = {srcA_q, 32'hFFFF_FFFF};
          wen_d    = 1'b1;
        end
`endif
      end
`ifdef MDU_DIV_EN
      DIV: begin
        divCnt_d = divCnt_q + 5'd1;
        rem_d    = remStep;
        quo_d    = quoStep;
        if (divCnt_q == 5'd31) begin
          state_d   = IDLE;
          result_d  = {remFinal, quoFinal};
          wen_d     = 1'b1;
          canLaunch = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (canLaunch && start && !cancel) begin
      op_d    = op;
      srcA_d  = src_a;
      srcB_d  = src_b;
      state_d = FAST;
`ifdef MDU_DIV_EN
      if (op[1] && (src_b != 32'd0)) begin
        state_d  = DIV;
        divCnt_d = 5'd0;
        rem_d    = 32'd0;
        quo_d    = launchDividendMag;
        negQuo_d = ~op[0] & (src_a[31] ^ src_b[31]);
        negRem_d = ~op[0] & src_a[31];
      end
`endif
    end

    if (cancel) begin
      state_d  = IDLE;
      wen_d    = 1'b0;
      result_d = result_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous reset to the idle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      srcA_q   <= 32'd0;
      srcB_q   <= 32'd0;
      result_q <= 64'd0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MDU_DIV_EN
      divCnt_q <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      srcA_q   <= srcA_d;
      srcB_q   <= srcB_d;
      result_q <= result_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
`ifdef MDU_DIV_EN
      divCnt_q <= divCnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign hilo_result = result_q;
  assign hilo_wen    = wen_q;

endmodule
